// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider: controller state
// encoding and the default operand width.
package divisor_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divisor_seq_control.sv
// DivControl: owns the IDLE/CALC/DONE sequencing and the iteration counter,
// and emits Load/Shift/Finish strobes for the divider datapath.
module DivControl
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Sy,
  output logic Load,
  output logic Shift,
  output logic Finish,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  div_state_t state;
  logic [CW-1:0] count;

  // Strobes decode the current state so the datapath acts on the same edge
  // the controller advances; Reset overrides them inside both blocks.
  assign Load   = (state == IDLE) && Sy;
  assign Shift  = (state == CALC);
  assign Finish = Shift && (count == LastIter);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      count <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Sy) begin
            state <= CALC;
            count <= '0;
            Busy  <= 1'b1;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (count == LastIter) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/divisor_seq.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle.
// Define DIV_ZERO_FLAG_EN to add the registered DivZero output.
module divisor_seq
  import divisor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Sy,
  input  logic [WIDTH-1:0] Dividendo,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quociente,
  output logic [WIDTH-1:0] Resto,
  output logic             Busy,
`ifdef DIV_ZERO_FLAG_EN
  output logic             DivZero,
`endif
  output logic             Done
);

  logic load, shift, finish;

  DivControl #(.WIDTH(WIDTH)) control (
    .Clk    (Clk),
    .Reset  (Reset),
    .Sy     (Sy),
    .Load   (load),
    .Shift  (shift),
    .Finish (finish),
    .Busy   (Busy),
    .Done   (Done)
  );

  logic [WIDTH:0]   remReg;
  logic [WIDTH-1:0] dvdReg;
  logic [WIDTH-1:0] dsrReg;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   remNext;
  logic [WIDTH-1:0] dvdNext;
  logic             qBit;

  // One iteration: the dividend register doubles as the quotient shift
  // register, and the top bit of the extended difference is the borrow.
  always_comb begin
    shifted = {remReg, dvdReg[WIDTH-1]};
    diff    = shifted - {2'b00, dsrReg};
    qBit    = ~diff[WIDTH+1];
    remNext = qBit ? diff[WIDTH:0] : shifted[WIDTH:0];
    dvdNext = {dvdReg[WIDTH-2:0], qBit};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      remReg    <= '0;
      dvdReg    <= '0;
      dsrReg    <= '0;
      Quociente <= '0;
      Resto     <= '0;
`ifdef DIV_ZERO_FLAG_EN
      DivZero   <= 1'b0;
`endif
    end else if (load) begin
      remReg  <= '0;
      dvdReg  <= Dividendo;
      dsrReg  <= Divisor;
`ifdef DIV_ZERO_FLAG_EN
      DivZero <= (Divisor == '0);
`endif
    end else if (shift) begin
      remReg <= remNext;
      dvdReg <= dvdNext;
      if (finish) begin
        Quociente <= dvdNext;
        Resto     <= remNext[WIDTH-1:0];
      end
    end
  end

endmodule
